// File: rtl/card_board_store.sv
`default_nettype none
// ============================================================================
// card_board_store: per-card state/colour board with click qualification and
// a shadowed, registered renderer read port.            Revision: 1.0
// ============================================================================
module card_board_store #(
  parameter int ADDR_W  = 5,
  parameter int COLOR_W = 12,
  parameter int STATE_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W:0]     num_of_cards,
  input  logic                init_en,
  input  logic                color_wr_en,
  input  logic [ADDR_W-1:0]   color_wr_addr,
  input  logic [COLOR_W-1:0]  color_wr_data,
  input  logic                write_card_en,
  input  logic [ADDR_W-1:0]   write_card_address,
  input  logic [STATE_W-1:0]  write_card_state,
  input  logic                update_cards_en,
  input  logic                wait_for_click_en,
  input  logic                mouse_click,
  input  logic                mouse_card_hit,
  input  logic [ADDR_W-1:0]   mouse_card_addr,
  output logic                card_pressed,
  output logic [ADDR_W-1:0]   card_clicked_address,
  output logic [COLOR_W-1:0]  card_clicked_color,
  output logic                init_busy,
  output logic                update_busy,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [STATE_W-1:0]  rd_state,
  output logic [COLOR_W-1:0]  rd_color
);

  localparam int SLOTS = 2**ADDR_W;
  localparam logic [ADDR_W:0]    c_slots   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0]  c_last    = '1;
  localparam logic [STATE_W-1:0] c_covered = {{(STATE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_UPDATE = 2'd2} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_idx, w_idx_next;
  logic                r_pending, w_pending_next;
  logic                r_init_hold;
  logic                r_lockout;
  logic [STATE_W-1:0]  r_work   [SLOTS];
  logic [STATE_W-1:0]  r_shadow [SLOTS];
  logic [COLOR_W-1:0]  r_color  [SLOTS];

  logic [ADDR_W:0]     w_n;
  logic [STATE_W-1:0]  w_init_val;
  logic [STATE_W-1:0]  w_copy_val;
  logic                w_click_ok;

  assign w_n        = (num_of_cards > c_slots) ? c_slots : num_of_cards;
  assign w_init_val = ({1'b0, r_idx} < w_n) ? c_covered : '0;
  // A write landing on the slot being copied this cycle is forwarded into the shadow.
  assign w_copy_val = (write_card_en && write_card_address == r_idx) ? write_card_state
                                                                     : r_work[r_idx];
  assign init_busy   = (r_state == S_INIT);
  assign update_busy = (r_state == S_UPDATE);

  assign w_click_ok = wait_for_click_en && mouse_click && mouse_card_hit &&
                      ({1'b0, mouse_card_addr} < w_n) &&
                      (r_work[mouse_card_addr] == c_covered) &&
                      !r_lockout && (r_state != S_INIT);

  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_pending_next = r_pending;
    if (r_state != S_IDLE && update_cards_en) w_pending_next = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (init_en && !r_init_hold) begin
          w_state_next = S_INIT;
          w_idx_next   = '0;
        end else if (update_cards_en || r_pending) begin
          w_state_next   = S_UPDATE;
          w_idx_next     = '0;
          w_pending_next = 1'b0;
        end
      end
      S_INIT: begin
        w_idx_next = r_idx + 1'b1;
        if (r_idx == c_last) w_state_next = S_IDLE;
      end
      S_UPDATE: begin
        w_idx_next = r_idx + 1'b1;
        // A pending request chains straight into a fresh sweep, keeping busy continuous.
        if (r_idx == c_last) begin
          if (r_pending || update_cards_en) w_pending_next = 1'b0;
          else                              w_state_next   = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_pending   <= 1'b0;
      r_init_hold <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_pending <= w_pending_next;
      if (!init_en)                              r_init_hold <= 1'b0;
      else if (r_state == S_INIT && r_idx == c_last) r_init_hold <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_work[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      if (r_state == S_INIT)  r_work[r_idx] <= w_init_val;
      else if (write_card_en) r_work[write_card_address] <= write_card_state;
      if (r_state == S_UPDATE) r_shadow[r_idx] <= w_copy_val;
    end
  end

  always_ff @(posedge clk) begin
    if (color_wr_en) r_color[color_wr_addr] <= color_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      card_pressed         <= 1'b0;
      card_clicked_address <= '0;
      card_clicked_color   <= '0;
      r_lockout            <= 1'b0;
      rd_state             <= '0;
      rd_color             <= '0;
    end else begin
      card_pressed <= w_click_ok;
      if (w_click_ok) begin
        card_clicked_address <= mouse_card_addr;
        card_clicked_color   <= r_color[mouse_card_addr];
      end
      if (!wait_for_click_en) r_lockout <= 1'b0;
      else if (w_click_ok)    r_lockout <= 1'b1;
      rd_state <= r_shadow[rd_addr];
      rd_color <= r_color[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_card_board_store.sv
`default_nettype none
// ============================================================================
// tb_card_board_store: randomized self-checking bench with a board model.
// Revision: 1.0
// ============================================================================
module tb_card_board_store;

  localparam int ADDR_W = 5, COLOR_W = 12, STATE_W = 2, SLOTS = 32;

  logic clk = 1'b0;
  logic rst;
  logic [ADDR_W:0]    num_of_cards;
  logic               init_en, color_wr_en, write_card_en, update_cards_en;
  logic               wait_for_click_en, mouse_click, mouse_card_hit;
  logic [ADDR_W-1:0]  color_wr_addr, write_card_address, mouse_card_addr, rd_addr;
  logic [COLOR_W-1:0] color_wr_data;
  logic [STATE_W-1:0] write_card_state;
  logic               card_pressed, init_busy, update_busy;
  logic [ADDR_W-1:0]  card_clicked_address;
  logic [COLOR_W-1:0] card_clicked_color;
  logic [STATE_W-1:0] rd_state;
  logic [COLOR_W-1:0] rd_color;

  int checks = 0;
  int fails  = 0;

  logic [1:0]  m_work  [SLOTS];
  logic [11:0] m_color [SLOTS];
  logic [4:0]  m_addr;
  logic [11:0] m_col;
  logic        m_lock;

  card_board_store #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W), .STATE_W(STATE_W)) dut (
    .clk(clk), .rst(rst), .num_of_cards(num_of_cards), .init_en(init_en),
    .color_wr_en(color_wr_en), .color_wr_addr(color_wr_addr), .color_wr_data(color_wr_data),
    .write_card_en(write_card_en), .write_card_address(write_card_address),
    .write_card_state(write_card_state), .update_cards_en(update_cards_en),
    .wait_for_click_en(wait_for_click_en), .mouse_click(mouse_click),
    .mouse_card_hit(mouse_card_hit), .mouse_card_addr(mouse_card_addr),
    .card_pressed(card_pressed), .card_clicked_address(card_clicked_address),
    .card_clicked_color(card_clicked_color), .init_busy(init_busy),
    .update_busy(update_busy), .rd_addr(rd_addr), .rd_state(rd_state), .rd_color(rd_color)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    init_en = 0; color_wr_en = 0; color_wr_addr = '0; color_wr_data = '0;
    write_card_en = 0; write_card_address = '0; write_card_state = '0;
    update_cards_en = 0; mouse_click = 0; mouse_card_hit = 0; mouse_card_addr = '0;
  endtask

  task automatic read_check(input int a, input logic [1:0] exp_s, input bit chk_col);
    rd_addr = 5'(a);
    tick;
    checks++;
    if (rd_state !== exp_s) begin
      fails++;
      $display("FAIL rd_state[%0d]: got %b expected %b", a, rd_state, exp_s);
    end
    if (chk_col) begin
      checks++;
      if (rd_color !== m_color[a]) begin
        fails++;
        $display("FAIL rd_color[%0d]: got %h expected %h", a, rd_color, m_color[a]);
      end
    end
  endtask

  task automatic run_update;
    int cnt = 0;
    update_cards_en = 1;
    tick;
    update_cards_en = 0;
    while (update_busy === 1'b1 && cnt < 200) begin
      tick;
      cnt++;
    end
    checks++;
    if (cnt != 32) begin
      fails++;
      $display("FAIL update_busy_len: got %0d cycles expected 32", cnt);
    end
  endtask

  task automatic do_init(input int n, input bit hold);
    int cnt = 0;
    int nc = (n > SLOTS) ? SLOTS : n;
    num_of_cards = 6'(n);
    init_en = 1;
    tick;
    if (!hold) init_en = 0;
    while (init_busy === 1'b1 && cnt < 200) begin
      tick;
      cnt++;
    end
    checks++;
    if (cnt != 32) begin
      fails++;
      $display("FAIL init_busy_len: got %0d cycles expected 32", cnt);
    end
    for (int i = 0; i < SLOTS; i++) m_work[i] = (i < nc) ? 2'b01 : 2'b00;
    if (hold) begin
      for (int k = 0; k < 10; k++) begin
        tick;
        checks++;
        if (init_busy !== 1'b0) begin
          fails++;
          $display("FAIL init_rearm: got init_busy %b expected 0 while held", init_busy);
        end
      end
      init_en = 0;
      tick;
    end
  endtask

  task automatic click(input int a, input bit hit, input bit exp_p);
    mouse_click = 1; mouse_card_hit = hit; mouse_card_addr = 5'(a);
    tick;
    mouse_click = 0; mouse_card_hit = 0;
    checks++;
    if (card_pressed !== exp_p || card_clicked_address !== m_addr || card_clicked_color !== m_col) begin
      fails++;
      $display("FAIL click[%0d]: got p=%b a=%0d c=%h expected p=%b a=%0d c=%h", a, card_pressed,
               card_clicked_address, card_clicked_color, exp_p, m_addr, m_col);
    end
    tick;
    checks++;
    if (card_pressed !== 1'b0) begin
      fails++;
      $display("FAIL pulse_width: got card_pressed %b expected 0", card_pressed);
    end
  endtask

  task automatic test_reset;
    rst = 1;
    idle_inputs();
    wait_for_click_en = 0; rd_addr = '0; num_of_cards = '0;
    m_addr = '0; m_col = '0; m_lock = 0;
    repeat (3) tick;
    checks++;
    if ({card_pressed, init_busy, update_busy, card_clicked_address, card_clicked_color, rd_state, rd_color} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got p=%b ib=%b ub=%b a=%h c=%h s=%b rc=%h expected all 0",
               card_pressed, init_busy, update_busy, card_clicked_address, card_clicked_color, rd_state, rd_color);
    end
    rst = 0;
    for (int i = 0; i < 4; i++) read_check(i * 9, 2'b00, 0);
  endtask

  task automatic test_init;
    do_init(16, 0);
    run_update();
    read_check(15, 2'b01, 0);
    read_check(16, 2'b00, 0);
    read_check(0, 2'b01, 0);
    do_init(16, 1);
  endtask

  task automatic test_click_accept;
    color_wr_en = 1; color_wr_addr = 5'd5; color_wr_data = 12'hF00;
    tick;
    color_wr_en = 0;
    m_color[5] = 12'hF00;
    wait_for_click_en = 1;
    tick;
    m_addr = 5'd5; m_col = 12'hF00;
    click(5, 1, 1);
    click(7, 1, 0);
    wait_for_click_en = 0;
    tick;
  endtask

  task automatic test_click_reject;
    write_card_en = 1; write_card_address = 5'd3; write_card_state = 2'b10;
    tick;
    write_card_en = 0;
    m_work[3] = 2'b10;
    wait_for_click_en = 1;
    tick;
    click(3, 1, 0);
    click(20, 1, 0);
    click(5, 0, 0);
    click(5, 1, 1);
    wait_for_click_en = 0;
    tick;
  endtask

  task automatic test_shadow;
    write_card_en = 1; write_card_address = 5'd2; write_card_state = 2'b11;
    tick;
    write_card_en = 0;
    m_work[2] = 2'b11;
    read_check(2, 2'b01, 0);
    run_update();
    read_check(2, 2'b11, 0);
  endtask

  task automatic test_back_to_back;
    int cnt = 0;
    update_cards_en = 1;
    tick;
    update_cards_en = 0;
    while (update_busy === 1'b1 && cnt < 300) begin
      update_cards_en = (cnt == 5);
      tick;
      cnt++;
    end
    update_cards_en = 0;
    checks++;
    if (cnt != 64) begin
      fails++;
      $display("FAIL pending_update: got %0d busy cycles expected 64", cnt);
    end
    tick;
  endtask

  task automatic test_random;
    int n, nc;
    logic q;
    n  = $urandom_range(0, 40);
    nc = (n > SLOTS) ? SLOTS : n;
    do_init(n, 0);
    for (int i = 0; i < SLOTS; i++) begin
      color_wr_en = 1; color_wr_addr = 5'(i); color_wr_data = 12'($urandom);
      m_color[i] = color_wr_data;
      tick;
    end
    color_wr_en = 0;
    wait_for_click_en = 0;
    tick;
    m_lock = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) wait_for_click_en = ~wait_for_click_en;
      mouse_click        = 1'($urandom_range(0, 1));
      mouse_card_hit     = ($urandom_range(0, 3) != 0);
      mouse_card_addr    = 5'($urandom_range(0, 31));
      write_card_en      = ($urandom_range(0, 2) == 0);
      write_card_address = ($urandom_range(0, 1) == 1) ? mouse_card_addr : 5'($urandom_range(0, 31));
      write_card_state   = 2'($urandom);
      q = wait_for_click_en && mouse_click && mouse_card_hit && (int'(mouse_card_addr) < nc) &&
          (m_work[mouse_card_addr] == 2'b01) && !m_lock;
      if (!wait_for_click_en) m_lock = 0;
      else if (q)             m_lock = 1;
      if (q) begin
        m_addr = mouse_card_addr;
        m_col  = m_color[mouse_card_addr];
      end
      if (write_card_en) m_work[write_card_address] = write_card_state;
      tick;
      checks++;
      if (card_pressed !== q || card_clicked_address !== m_addr || card_clicked_color !== m_col) begin
        fails++;
        $display("FAIL rand_click[%0d]: got p=%b a=%0d c=%h expected p=%b a=%0d c=%h", c, card_pressed,
                 card_clicked_address, card_clicked_color, q, m_addr, m_col);
      end
    end
    idle_inputs();
    wait_for_click_en = 0;
    tick;
    run_update();
    for (int i = 0; i < SLOTS; i++) read_check(i, m_work[i], 1);
  endtask

  task automatic test_reset_mid_init;
    num_of_cards = 6'd16;
    init_en = 1;
    tick;
    init_en = 0;
    repeat (9) tick;
    rst = 1;
    tick;
    rst = 0;
    checks++;
    if (init_busy !== 1'b0 || card_pressed !== 1'b0 || update_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_init: got ib=%b p=%b ub=%b expected 0 0 0", init_busy, card_pressed, update_busy);
    end
    repeat (3) tick;
    checks++;
    if (init_busy !== 1'b0) begin
      fails++;
      $display("FAIL init_abort: got init_busy %b expected 0", init_busy);
    end
    for (int i = 0; i < SLOTS; i++) m_work[i] = 2'b00;
    run_update();
    for (int i = 0; i < SLOTS; i++) read_check(i, 2'b00, 0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_click_accept();
    test_click_reject();
    test_shadow();
    test_back_to_back();
    test_random();
    test_random();
    test_reset_mid_init();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
